// File: rtl/network_ejector_pkg.sv
// Shared types for the VC ejector: flit type encoding, arbiter states and a
// small circular-increment helper used for the round-robin pointer.
// Imported by the ejector top; no ports, no state.
package network_ejector_pkg;

  localparam int FlitTypeWidthDefault = 2;

  typedef enum logic [FlitTypeWidthDefault-1:0] {
    HEADER      = 2'd0,
    BODY        = 2'd1,
    TAIL        = 2'd2,
    HEADER_TAIL = 2'd3
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // (v + 1) mod n, for 0 <= v < n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/network_vc_ejector_buffer_if.sv
// Link + local-output bundle of the VC ejector.
// Link side: valid/flit/flit_type/broadcast/virtual_identifier in, per-VC ready out.
// Local side: out_valid/out_* out, out_ready in. slave = ejector, master = its environment.
interface network_vc_ejector_buffer_if #(
  parameter int FlitWidth                          = 64,
  parameter int FlitTypeWidth                      = 2,
  parameter int BroadcastWidth                     = 1,
  parameter int VirtualNetworkOrChannelIdWidth     = 2,
  parameter int NumberOfVirtualNetworksOrChannels  = 3
);

  logic                                         valid;
  logic [FlitWidth-1:0]                         flit;
  logic [FlitTypeWidth-1:0]                     flit_type;
  logic [BroadcastWidth-1:0]                    broadcast;
  logic [VirtualNetworkOrChannelIdWidth-1:0]    virtual_identifier;
  logic [NumberOfVirtualNetworksOrChannels-1:0] ready;

  logic                                         out_valid;
  logic                                         out_ready;
  logic [FlitWidth-1:0]                         out_flit;
  logic [FlitTypeWidth-1:0]                     out_flit_type;
  logic [BroadcastWidth-1:0]                    out_broadcast;
  logic [VirtualNetworkOrChannelIdWidth-1:0]    out_virtual_identifier;

  modport master (
    output valid, flit, flit_type, broadcast, virtual_identifier, out_ready,
    input  ready, out_valid, out_flit, out_flit_type, out_broadcast, out_virtual_identifier
  );

  modport slave (
    input  valid, flit, flit_type, broadcast, virtual_identifier, out_ready,
    output ready, out_valid, out_flit, out_flit_type, out_broadcast, out_virtual_identifier
  );

endinterface

// File: rtl/network_vc_fifo.sv
// Per-VC synchronous FIFO; head_data is the registered head entry (fall-through next cycle).
// Ports: push/push_data write, pop advances head, full/empty/count from registered occupancy.
// Caller never pushes when full nor pops when empty; simultaneous push+pop keeps count.
module network_vc_fifo #(
  parameter  int Width = 8,
  parameter  int Depth = 4,
  localparam int PtrW  = $clog2(Depth),
  localparam int CntW  = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count,
  output logic [Width-1:0] head_data
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  cnt;

  // Storage is not reset; contents are only observable through a non-empty head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign full      = (cnt == CntW'(Depth));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/network_vc_ejector_buffer.sv
// NoC ejection buffer: per-VN/VC FIFOs drained by a packet-aware round-robin arbiter.
// Ports: clk, rst (sync, active-high), bus (link in / local out), error_bad_vid (sticky).
// Latency >= 1 cycle; ready[i] = FIFO i not full (registered), no path from out_ready.
// NETWORK_VC_EJECTOR_STATS_EN adds flits_ejected (32b per VC) and max_occupancy ports.
module network_vc_ejector_buffer
  import network_ejector_pkg::*;
#(
  parameter  int FlitWidth                         = 64,
  parameter  int FlitTypeWidth                     = FlitTypeWidthDefault,
  parameter  int BroadcastWidth                    = 1,
  parameter  int VirtualNetworkOrChannelIdWidth    = 2,
  parameter  int NumberOfVirtualNetworksOrChannels = 3,
  parameter  int FifoDepth                         = 4,
  localparam int CntW                              = $clog2(FifoDepth) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  network_vc_ejector_buffer_if.slave bus,
  output logic                    error_bad_vid
`ifdef NETWORK_VC_EJECTOR_STATS_EN
  ,
  output logic [NumberOfVirtualNetworksOrChannels*32-1:0]   flits_ejected,
  output logic [NumberOfVirtualNetworksOrChannels*CntW-1:0] max_occupancy
`endif
);

  localparam int N        = NumberOfVirtualNetworksOrChannels;
  localparam int IdW      = VirtualNetworkOrChannelIdWidth;
  localparam int EntryW   = FlitWidth + FlitTypeWidth + BroadcastWidth;
  localparam int NumSlots = 1 << IdW;

  localparam logic [FlitTypeWidth-1:0] TypeHeader     = FlitTypeWidth'(HEADER);
  localparam logic [FlitTypeWidth-1:0] TypeTail       = FlitTypeWidth'(TAIL);
  localparam logic [FlitTypeWidth-1:0] TypeHeaderTail = FlitTypeWidth'(HEADER_TAIL);

  logic [N-1:0]                 push;
  logic [N-1:0]                 pop;
  logic [N-1:0]                 full;
  logic [N-1:0]                 empty;
  logic [N-1:0][CntW-1:0]       count;
  logic [N-1:0][EntryW-1:0]     head;

  // Padded to the full identifier space so an IdW-bit select is always in range.
  logic [NumSlots-1:0]              empty_pad;
  logic [NumSlots-1:0][EntryW-1:0]  head_pad;

  logic vid_in_range;
  logic xfer;

  arb_state_t      state_q, state_d;
  logic [IdW-1:0]  lock_q, lock_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [IdW-1:0]  idle_grant;
  logic            idle_found;
  logic [IdW:0]    cand_w;
  logic [IdW-1:0]  sel;
  logic            out_vld;

  logic [EntryW-1:0]         head_sel;
  logic [FlitWidth-1:0]      head_flit;
  logic [FlitTypeWidth-1:0]  head_type;
  logic [BroadcastWidth-1:0] head_bcast;

  assign vid_in_range = (32'(bus.virtual_identifier) < N);

  // ready comes from the registered occupancy only; forced low during reset.
  always_comb begin
    bus.ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.ready[i] = !rst && (count[i] != CntW'(FifoDepth));
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_vc
    assign push[i] = bus.valid && vid_in_range &&
                     (bus.virtual_identifier == IdW'(i)) && !full[i];
    assign pop[i]  = xfer && (sel == IdW'(i));

    network_vc_fifo #(
      .Width (EntryW),
      .Depth (FifoDepth)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data ({bus.flit, bus.flit_type, bus.broadcast}),
      .pop       (pop[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .count     (count[i]),
      .head_data (head[i])
    );
  end

  for (genvar s = 0; s < NumSlots; s++) begin : g_pad
    if (s < N) begin : g_real
      assign empty_pad[s] = empty[s];
      assign head_pad[s]  = head[s];
    end else begin : g_none
      assign empty_pad[s] = 1'b1;
      assign head_pad[s]  = '0;
    end
  end

  // Bad identifiers are dropped at the link; remember that it happened.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_bad_vid <= 1'b0;
    end else if (bus.valid && !vid_in_range) begin
      error_bad_vid <= 1'b1;
    end
  end

  // Round-robin search: first non-empty VC at or after ptr_q, circularly.
  always_comb begin
    idle_found = 1'b0;
    idle_grant = ptr_q;
    cand_w     = '0;
    for (int k = 0; k < N; k++) begin
      cand_w = {1'b0, ptr_q} + (IdW+1)'(k);
      if (cand_w >= (IdW+1)'(N)) begin
        cand_w = cand_w - (IdW+1)'(N);
      end
      if (!idle_found && !empty_pad[cand_w[IdW-1:0]]) begin
        idle_found = 1'b1;
        idle_grant = cand_w[IdW-1:0];
      end
    end
  end

  // While locked, an empty FIFO gives bubbles rather than a VC switch.
  assign sel     = (state_q == LOCKED) ? lock_q : idle_grant;
  assign out_vld = (state_q == LOCKED) ? !empty_pad[lock_q] : idle_found;
  assign xfer    = out_vld && bus.out_ready;

  assign head_sel   = head_pad[sel];
  assign head_flit  = head_sel[EntryW-1 -: FlitWidth];
  assign head_type  = head_sel[BroadcastWidth +: FlitTypeWidth];
  assign head_bcast = head_sel[BroadcastWidth-1:0];

  assign bus.out_valid              = out_vld;
  assign bus.out_flit               = out_vld ? head_flit  : '0;
  assign bus.out_flit_type          = out_vld ? head_type  : '0;
  assign bus.out_broadcast          = out_vld ? head_bcast : '0;
  assign bus.out_virtual_identifier = out_vld ? sel        : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

  // Any non-HEADER flit seen in IDLE is treated as a complete packet, and a
  // HEADER_TAIL seen while locked closes the packet like a TAIL, so a
  // malformed stream can never wedge the arbiter.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      case (state_q)
        IDLE: begin
          if (head_type == TypeHeader) begin
            state_d = LOCKED;
            lock_d  = sel;
          end else begin
            ptr_d = IdW'(wrap_inc(int'(sel), N));
          end
        end
        LOCKED: begin
          if (head_type == TypeTail || head_type == TypeHeaderTail) begin
            state_d = IDLE;
            ptr_d   = IdW'(wrap_inc(int'(lock_q), N));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef NETWORK_VC_EJECTOR_STATS_EN
  logic [N-1:0][31:0]     ejected_q;
  logic [N-1:0][CntW-1:0] max_occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ejected_q <= '0;
      max_occ_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pop[i]) ejected_q[i] <= ejected_q[i] + 32'd1;
        if (count[i] > max_occ_q[i]) max_occ_q[i] <= count[i];
      end
    end
  end

  assign flits_ejected = ejected_q;
  assign max_occupancy = max_occ_q;
`endif

endmodule

// File: tb/tb_network_vc_ejector_buffer.sv
// Directed bench for network_vc_ejector_buffer: stimulus pushes expected output
// flits into a queue, an independent monitor pops and compares on each transfer.
module tb_network_vc_ejector_buffer;
  import network_ejector_pkg::*;

  localparam int FW = 64;
  localparam int TW = 2;
  localparam int BW = 1;
  localparam int IW = 2;
  localparam int N  = 3;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst;
  logic err;

  always #5 clk = ~clk;

  network_vc_ejector_buffer_if #(
    .FlitWidth(FW), .FlitTypeWidth(TW), .BroadcastWidth(BW),
    .VirtualNetworkOrChannelIdWidth(IW), .NumberOfVirtualNetworksOrChannels(N)
  ) bus ();

  network_vc_ejector_buffer #(
    .FlitWidth(FW), .FlitTypeWidth(TW), .BroadcastWidth(BW),
    .VirtualNetworkOrChannelIdWidth(IW), .NumberOfVirtualNetworksOrChannels(N),
    .FifoDepth(D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .error_bad_vid (err)
  );

  typedef struct packed {
    logic [1:0]  vid;
    logic [1:0]  ftype;
    logic        bcast;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_exp(input int vid, input flit_type_t t, input logic [63:0] d);
    exp_t e;
    e.vid   = 2'(vid);
    e.ftype = t;
    e.bcast = d[0];
    e.data  = d;
    exp_q.push_back(e);
  endfunction

  // Monitor: every output transfer must match the head of the expected queue.
  exp_t got;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual flit=%0h vid=%0d required=no output",
                 bus.out_flit, bus.out_virtual_identifier);
      end else begin
        got = exp_q.pop_front();
        chk("out_flit", bus.out_flit, got.data);
        chk("out_virtual_identifier", 64'(bus.out_virtual_identifier), 64'(got.vid));
        chk("out_flit_type", 64'(bus.out_flit_type), 64'(got.ftype));
        chk("out_broadcast", 64'(bus.out_broadcast), 64'(got.bcast));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the flit was accepted.
  task automatic send(input int vid, input flit_type_t t, input logic [63:0] d);
    int n = 0;
    bus.valid              = 1'b1;
    bus.virtual_identifier = 2'(vid);
    bus.flit_type          = t;
    bus.flit               = d;
    bus.broadcast          = d[0];
    @(negedge clk);
    while (!bus.ready[vid] && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout vc=%0d actual ready=%b required ready[vc]=1", vid, bus.ready);
    end
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required pending=0", exp_q.size());
    end
  endtask

  initial begin
    rst                    = 1'b1;
    bus.valid              = 1'b0;
    bus.flit               = '0;
    bus.flit_type          = '0;
    bus.broadcast          = '0;
    bus.virtual_identifier = '0;
    bus.out_ready          = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_in_reset", 64'(bus.ready), 64'h0);
    chk("out_valid_in_reset", 64'(bus.out_valid), 64'h0);
    chk("out_flit_in_reset", bus.out_flit, 64'h0);
    chk("err_in_reset", 64'(err), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.ready), 64'h7);
    chk("out_valid_after_reset", 64'(bus.out_valid), 64'h0);
    @(posedge clk); #1;

    // Single HEADER_TAIL on VC1, visible the cycle after acceptance
    bus.out_ready = 1'b1;
    push_exp(1, HEADER_TAIL, 64'hA5);
    send(1, HEADER_TAIL, 64'hA5);
    @(negedge clk);
    chk("t1_latency_out_valid", 64'(bus.out_valid), 64'h1);
    wait_drain(10);

    // Fill VC0 with out_ready low; 5th flit must be refused
    bus.out_ready = 1'b0;
    push_exp(0, HEADER, 64'h10);
    push_exp(0, BODY,   64'h11);
    push_exp(0, BODY,   64'h12);
    push_exp(0, TAIL,   64'h13);
    send(0, HEADER, 64'h10);
    send(0, BODY,   64'h11);
    send(0, BODY,   64'h12);
    send(0, TAIL,   64'h13);
    @(negedge clk);
    chk("t2_ready_full", 64'(bus.ready), 64'h6);
    chk("t2_hold_flit", bus.out_flit, 64'h10);
    bus.valid              = 1'b1;
    bus.virtual_identifier = 2'd0;
    bus.flit_type          = BODY;
    bus.flit               = 64'h14;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    @(negedge clk);
    chk("t2_ready_still_full", 64'(bus.ready), 64'h6);
    chk("t2_hold_flit_stable", bus.out_flit, 64'h10);
    chk("t2_hold_valid", 64'(bus.out_valid), 64'h1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain(20);
    repeat (3) @(negedge clk);
    chk("t2_ready_after_drain", 64'(bus.ready), 64'h7);
    @(posedge clk); #1;

    // Interleaved packets on VC0 and VC2 come out packet-contiguous
    push_exp(0, HEADER, 64'h20);
    push_exp(0, BODY,   64'h21);
    push_exp(0, TAIL,   64'h22);
    push_exp(2, HEADER, 64'h30);
    push_exp(2, BODY,   64'h31);
    push_exp(2, TAIL,   64'h32);
    send(0, HEADER, 64'h20);
    send(2, HEADER, 64'h30);
    send(0, BODY,   64'h21);
    send(2, BODY,   64'h31);
    send(0, TAIL,   64'h22);
    send(2, TAIL,   64'h32);
    wait_drain(30);

    // Pointer now 0: VC0 beats older VC1 data; locked VC0 bubbles while body is late
    bus.out_ready = 1'b0;
    push_exp(0, HEADER,      64'h50);
    push_exp(0, BODY,        64'h51);
    push_exp(0, TAIL,        64'h52);
    push_exp(1, HEADER_TAIL, 64'h40);
    send(1, HEADER_TAIL, 64'h40);
    send(0, HEADER,      64'h50);
    @(negedge clk);
    chk("t4_grant_from_ptr0", 64'(bus.out_virtual_identifier), 64'h0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      chk("t4_bubble_out_valid", 64'(bus.out_valid), 64'h0);
    end
    @(posedge clk); #1;
    send(0, BODY, 64'h51);
    send(0, TAIL, 64'h52);
    wait_drain(20);

    // Out-of-range identifier: dropped, sticky error
    @(posedge clk); #1;
    bus.valid              = 1'b1;
    bus.virtual_identifier = 2'd3;
    bus.flit_type          = HEADER_TAIL;
    bus.flit               = 64'hEE;
    @(negedge clk);
    chk("t5_err_before", 64'(err), 64'h0);
    @(posedge clk); #1;
    bus.valid = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 64'(err), 64'h1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5_err_sticky", 64'(err), 64'h1);
    chk("t5_ready", 64'(bus.ready), 64'h7);
    @(posedge clk); #1;

    // Reset mid-packet discards buffered flits; new packet from pointer 0
    bus.out_ready = 1'b0;
    send(0, HEADER, 64'h60);
    send(0, BODY,   64'h61);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid_after_rst", 64'(bus.out_valid), 64'h0);
    chk("t6_ready_after_rst", 64'(bus.ready), 64'h7);
    chk("t6_err_cleared", 64'(err), 64'h0);
    @(posedge clk); #1;
    push_exp(2, HEADER_TAIL, 64'h70);
    send(2, HEADER_TAIL, 64'h70);
    bus.out_ready = 1'b1;
    wait_drain(10);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "timeout");
  end

endmodule
